// File: rtl/mandelbrot_scanner.sv
// Frame scanner for a Mandelbrot iteration core: walks a width x height pixel
// grid, issues one core job per pixel and packs four 4-bit results per memory word.
module mandelbrot_scanner #(
  parameter int ADDR_WIDTH = 12
) (
  input  logic                  raw_clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  abort,
  input  logic signed [15:0]    r0,
  input  logic signed [15:0]    i0,
  input  logic signed [15:0]    dr,
  input  logic signed [15:0]    di,
  input  logic [7:0]            width,
  input  logic [7:0]            height,
  output logic                  core_start,
  output logic [15:0]           core_r,
  output logic [15:0]           core_i,
  input  logic [3:0]            core_result,
  input  logic                  core_busy,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [15:0]           mem_data,
  output logic                  mem_we,
  output logic                  busy,
  output logic                  done
);

  typedef enum logic [2:0] {
    IDLE, ISSUE, WAIT_BUSY, WAIT_DONE, STORE, FLUSH, FINISH
  } state_t;

  state_t      state, next_state;

  logic [7:0]  w_q, h_q, x, y;
  logic [15:0] r0_q, dr_q, di_q;
  logic [15:0] cur_r, cur_i;
  logic [1:0]  k;
  logic [15:0] pack;
  logic [3:0]  result_q;
  logic        abort_pend;

  logic        x_last, last_pixel;

  assign x_last     = (x == w_q - 8'd1);
  assign last_pixel = x_last && (y == h_q - 8'd1);

  // The coordinate registers drive the core directly, so they hold steady
  // from ISSUE until STORE advances them.
  assign core_r = cur_r;
  assign core_i = cur_i;

  // NOTE: every signal written here gets a default first, so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    next_state = state;
    core_start = 1'b0;
    busy       = (state != IDLE);
    done       = 1'b0;
    mem_we     = 1'b0;
    mem_data   = '0;

    case (state)
      IDLE: begin
        if (start && !abort)
          next_state = (width == 8'd0 || height == 8'd0) ? FINISH : ISSUE;
      end
      ISSUE: begin
        core_start = 1'b1;
        next_state = WAIT_BUSY;
      end
      WAIT_BUSY: begin
        if (core_busy) next_state = WAIT_DONE;
      end
      WAIT_DONE: begin
        if (!core_busy) next_state = (abort || abort_pend) ? IDLE : STORE;
      end
      STORE: begin
        if (k == 2'd3) begin
          mem_we   = 1'b1;
          mem_data = {result_q, pack[11:0]};
        end
        if (abort)           next_state = IDLE;
        else if (last_pixel) next_state = FLUSH;
        else                 next_state = ISSUE;
      end
      FLUSH: begin
        // Unused upper nibbles are already zero because pack is cleared per word.
        if (k != 2'd0) begin
          mem_we   = 1'b1;
          mem_data = pack;
        end
        next_state = abort ? IDLE : FINISH;
      end
      FINISH: begin
        done       = 1'b1;
        next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  // NOTE: state is updated with non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge raw_clk) begin
    if (reset) begin
      state      <= IDLE;
      w_q        <= '0;
      h_q        <= '0;
      x          <= '0;
      y          <= '0;
      r0_q       <= '0;
      dr_q       <= '0;
      di_q       <= '0;
      cur_r      <= '0;
      cur_i      <= '0;
      k          <= '0;
      pack       <= '0;
      result_q   <= '0;
      abort_pend <= 1'b0;
      mem_addr   <= '0;
    end else begin
      state <= next_state;
      case (state)
        IDLE: begin
          abort_pend <= 1'b0;
          if (start && !abort) begin
            w_q      <= width;
            h_q      <= height;
            r0_q     <= r0;
            dr_q     <= dr;
            di_q     <= di;
            x        <= '0;
            y        <= '0;
            cur_r    <= r0;
            cur_i    <= i0;
            mem_addr <= '0;
            k        <= '0;
            pack     <= '0;
          end
        end
        ISSUE, WAIT_BUSY: begin
          if (abort) abort_pend <= 1'b1;
        end
        WAIT_DONE: begin
          if (abort)      abort_pend <= 1'b1;
          if (!core_busy) result_q   <= core_result;
        end
        STORE: begin
          if (k == 2'd3) begin
            mem_addr <= mem_addr + ADDR_WIDTH'(1);
            pack     <= '0;
            k        <= '0;
          end else begin
            pack[{k, 2'b00} +: 4] <= result_q;
            k                     <= k + 2'd1;
          end
          if (!x_last) begin
            x     <= x + 8'd1;
            cur_r <= cur_r + dr_q;
          end else begin
            x     <= '0;
            cur_r <= r0_q;
            y     <= y + 8'd1;
            cur_i <= cur_i + di_q;
          end
        end
        FLUSH: begin
          if (k != 2'd0) begin
            mem_addr <= mem_addr + ADDR_WIDTH'(1);
            pack     <= '0;
            k        <= '0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mandelbrot_scanner.sv
// Bench for mandelbrot_scanner: a behavioural iteration core plus a write
// scoreboard filled from the bench's own walk of each frame's pixel grid.
module tb_mandelbrot_scanner;
  localparam int AW  = 12;
  localparam int LAT = 3;

  logic          raw_clk = 1'b0;
  logic          reset, start, abort;
  logic [15:0]   r0, i0, dr, di;
  logic [7:0]    width, height;
  logic          core_start;
  logic [15:0]   core_r, core_i;
  logic [3:0]    core_result;
  logic          core_busy;
  logic [AW-1:0] mem_addr;
  logic [15:0]   mem_data;
  logic          mem_we, busy, done;

  mandelbrot_scanner #(.ADDR_WIDTH(AW)) dut (
    .raw_clk(raw_clk), .reset(reset), .start(start), .abort(abort),
    .r0(r0), .i0(i0), .dr(dr), .di(di), .width(width), .height(height),
    .core_start(core_start), .core_r(core_r), .core_i(core_i),
    .core_result(core_result), .core_busy(core_busy),
    .mem_addr(mem_addr), .mem_data(mem_data), .mem_we(mem_we),
    .busy(busy), .done(done)
  );

  always #5 raw_clk = ~raw_clk;

  int total = 0;
  int bad   = 0;
  int n_cs  = 0;
  int n_we  = 0;
  int n_done = 0;

  typedef struct {
    logic [AW-1:0] addr;
    logic [15:0]   data;
  } wr_t;
  wr_t exp_q[$];
  wr_t mon_e;

  // Escape-time count, 6.10 fixed point: z starts at c, escape when |z|^2 >= 4.
  function automatic logic [3:0] mandel(input logic [15:0] cr, input logic [15:0] ci);
    longint zr, zi, c_r, c_i, t;
    c_r = longint'($signed(cr));
    c_i = longint'($signed(ci));
    zr = c_r;
    zi = c_i;
    for (int n = 0; n < 15; n++) begin
      if (zr * zr + zi * zi >= (longint'(4) <<< 20)) return 4'(n);
      t  = ((zr * zr - zi * zi) >>> 10) + c_r;
      zi = ((2 * zr * zi) >>> 10) + c_i;
      zr = t;
    end
    return 4'd15;
  endfunction

  // Behavioural core: busy for LAT cycles after core_start, result valid as busy falls.
  int         stub_cnt;
  logic [3:0] stub_res;
  always @(posedge raw_clk) begin
    if (reset) begin
      core_busy   <= 1'b0;
      core_result <= 4'd0;
      stub_cnt    <= 0;
    end else if (core_start && !core_busy) begin
      core_busy <= 1'b1;
      stub_cnt  <= LAT - 1;
      stub_res  <= mandel(core_r, core_i);
    end else if (core_busy) begin
      if (stub_cnt == 0) begin
        core_busy   <= 1'b0;
        core_result <= stub_res;
      end else begin
        stub_cnt <= stub_cnt - 1;
      end
    end
  end

  // Write monitor: every mem_we must match the head of the scoreboard.
  always @(posedge raw_clk) begin
    #1;
    if (!reset) begin
      if (core_start) n_cs++;
      if (done) n_done++;
      if (mem_we) begin
        n_we++;
        total++;
        if (exp_q.size() == 0) begin
          bad++;
          $display("FAIL unexpected_write addr=%h data=%h (no write expected)", mem_addr, mem_data);
        end else begin
          mon_e = exp_q.pop_front();
          if (mem_addr !== mon_e.addr || mem_data !== mon_e.data) begin
            bad++;
            $display("FAIL write got addr=%h data=%h want addr=%h data=%h",
                     mem_addr, mem_data, mon_e.addr, mon_e.data);
          end
        end
      end
    end
  end

  task automatic push_frame(input logic [7:0] w, input logic [7:0] h,
                            input logic [15:0] r0v, input logic [15:0] i0v,
                            input logic [15:0] drv, input logic [15:0] div);
    logic [15:0]   word, cr, ci;
    logic [AW-1:0] a;
    int            kk;
    wr_t           e;
    word = '0; kk = 0; a = '0; ci = i0v;
    for (int yy = 0; yy < int'(h); yy++) begin
      cr = r0v;
      for (int xx = 0; xx < int'(w); xx++) begin
        word[4*kk +: 4] = mandel(cr, ci);
        kk++;
        if (kk == 4) begin
          e.addr = a; e.data = word; exp_q.push_back(e);
          a++; word = '0; kk = 0;
        end
        cr = cr + drv;
      end
      ci = ci + div;
    end
    if (kk != 0) begin
      e.addr = a; e.data = word; exp_q.push_back(e);
    end
  endtask

  task automatic start_frame(input logic [7:0] w, input logic [7:0] h,
                             input logic [15:0] r0v, input logic [15:0] i0v,
                             input logic [15:0] drv, input logic [15:0] div);
    width = w; height = h; r0 = r0v; i0 = i0v; dr = drv; di = div;
    start = 1'b1;
    @(negedge raw_clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input string name, output int cycles);
    cycles = -1;
    for (int i = 0; i < 3000; i++) begin
      if (done) begin cycles = i; break; end
      @(negedge raw_clk);
    end
    total++;
    if (cycles < 0) begin
      bad++;
      $display("FAIL %s_done_timeout got no done, want done within 3000 cycles", name);
    end
  endtask

  task automatic wait_cs(input string name, input int target);
    int ok = 0;
    for (int i = 0; i < 500; i++) begin
      if (n_cs >= target) begin ok = 1; break; end
      @(negedge raw_clk);
    end
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL %s_core_start_timeout got %0d starts want %0d", name, n_cs, target);
    end
  endtask

  task automatic wait_idle(input string name);
    int ok = 0;
    for (int i = 0; i < 500; i++) begin
      if (!busy) begin ok = 1; break; end
      @(negedge raw_clk);
    end
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL %s_idle_timeout got busy=1 want busy=0 within 500 cycles", name);
    end
  endtask

  task automatic run_frame(input string name, input logic [7:0] w, input logic [7:0] h,
                           input logic [15:0] r0v, input logic [15:0] i0v,
                           input logic [15:0] drv, input logic [15:0] div);
    int cyc;
    push_frame(w, h, r0v, i0v, drv, div);
    start_frame(w, h, r0v, i0v, drv, div);
    total++;
    if (busy !== 1'b1) begin
      bad++; $display("FAIL %s_busy_after_start got %b want 1", name, busy);
    end
    wait_done(name, cyc);
    total++;
    if (exp_q.size() != 0) begin
      bad++; $display("FAIL %s_writes_before_done got %0d pending want 0", name, exp_q.size());
      exp_q.delete();
    end
    @(negedge raw_clk);
    total++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      bad++; $display("FAIL %s_after_done got done=%b busy=%b want 0 0", name, done, busy);
    end
  endtask

  task automatic check_reset_outputs(input string name);
    total++;
    if ({core_start, mem_we, done, busy} !== 4'b0000 || mem_addr !== '0 ||
        mem_data !== 16'h0 || core_r !== 16'h0 || core_i !== 16'h0) begin
      bad++;
      $display("FAIL %s got cs=%b we=%b done=%b busy=%b addr=%h data=%h r=%h i=%h want all 0",
               name, core_start, mem_we, done, busy, mem_addr, mem_data, core_r, core_i);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge raw_clk);
    check_reset_outputs("reset_state");
    reset = 1'b0;
    @(negedge raw_clk);
    check_reset_outputs("idle_after_reset");
  endtask

  task automatic test_single_pixel();
    run_frame("single_1x1", 8'd1, 8'd1, 16'h0, 16'h0, 16'h0, 16'h0);
  endtask

  task automatic test_two_by_two();
    run_frame("grid_2x2", 8'd2, 8'd2, 16'h0, 16'h0, 16'h0800, 16'h0);
  endtask

  task automatic test_flush_and_throughput();
    int cs0, gap, cyc;
    push_frame(8'd5, 8'd1, 16'h0, 16'h0, 16'h0, 16'h0);
    start_frame(8'd5, 8'd1, 16'h0, 16'h0, 16'h0, 16'h0);
    cs0 = n_cs;
    gap = -1;
    for (int i = 1; i <= 100; i++) begin
      @(negedge raw_clk);
      if (core_start) begin gap = i; break; end
    end
    total++;
    if (gap != LAT + 3) begin
      bad++; $display("FAIL pixel_period got %0d want %0d", gap, LAT + 3);
    end
    wait_done("flush_5x1", cyc);
    total++;
    if (exp_q.size() != 0 || n_cs - cs0 != 4) begin
      bad++; $display("FAIL flush_5x1_counts got pending=%0d starts=%0d want 0 4",
                      exp_q.size(), n_cs - cs0);
      exp_q.delete();
    end
    @(negedge raw_clk);
  endtask

  task automatic test_mixed_frames();
    run_frame("mixed_3x3", 8'd3, 8'd3, 16'hF800, 16'hFC00, 16'h0400, 16'h0400);
    run_frame("exact_4x2", 8'd4, 8'd2, 16'hF400, 16'hFE00, 16'h0200, 16'h0300);
    run_frame("wrap_4x1", 8'd4, 8'd1, 16'h4000, 16'h0, 16'h4000, 16'h0);
    run_frame("wide_7x3", 8'd7, 8'd3, 16'hF000, 16'hFB00, 16'h0180, 16'h0380);
  endtask

  task automatic test_zero_size();
    int cs0, we0, cyc;
    cs0 = n_cs; we0 = n_we;
    start_frame(8'd0, 8'd5, 16'h0, 16'h0, 16'h0, 16'h0);
    wait_done("zero_width", cyc);
    total++;
    if (cyc != 0) begin
      bad++; $display("FAIL zero_width_latency got %0d want 0 extra cycles", cyc);
    end
    @(negedge raw_clk);
    start_frame(8'd3, 8'd0, 16'h0, 16'h0, 16'h0, 16'h0);
    wait_done("zero_height", cyc);
    repeat (3) @(negedge raw_clk);
    total++;
    if (n_cs != cs0 || n_we != we0 || busy !== 1'b0) begin
      bad++; $display("FAIL zero_size_activity got starts=%0d writes=%0d busy=%b want 0 0 0",
                      n_cs - cs0, n_we - we0, busy);
    end
  endtask

  task automatic test_abort_wait_done();
    int cs0, we0, dn0, ok;
    cs0 = n_cs; we0 = n_we; dn0 = n_done;
    start_frame(8'd5, 8'd1, 16'h0, 16'h0, 16'h0, 16'h0);
    wait_cs("abort_wd", cs0 + 3);
    ok = 0;
    for (int i = 0; i < 50; i++) begin
      if (core_busy) begin ok = 1; break; end
      @(negedge raw_clk);
    end
    total++;
    if (!ok) begin bad++; $display("FAIL abort_wd_core_busy got 0 want 1"); end
    @(negedge raw_clk);
    abort = 1'b1;
    @(negedge raw_clk);
    abort = 1'b0;
    wait_idle("abort_wd");
    total++;
    if (core_busy !== 1'b0) begin
      bad++; $display("FAIL abort_wd_core_finished got core_busy=%b want 0", core_busy);
    end
    repeat (10) @(negedge raw_clk);
    total++;
    if (n_we != we0 || n_done != dn0 || n_cs != cs0 + 3) begin
      bad++; $display("FAIL abort_wd_quiet got writes=%0d dones=%0d starts=%0d want 0 0 3",
                      n_we - we0, n_done - dn0, n_cs - cs0);
    end
    run_frame("after_abort", 8'd1, 8'd1, 16'h0800, 16'h0, 16'h0, 16'h0);
  endtask

  task automatic test_abort_issue();
    int cs0, we0, dn0;
    cs0 = n_cs; we0 = n_we; dn0 = n_done;
    start_frame(8'd5, 8'd1, 16'h0, 16'h0, 16'h0, 16'h0);
    wait_cs("abort_is", cs0 + 1);
    for (int i = 0; i < 50; i++) begin
      @(negedge raw_clk);
      if (core_start) break;
    end
    abort = 1'b1;
    @(negedge raw_clk);
    abort = 1'b0;
    total++;
    if (busy !== 1'b1) begin
      bad++; $display("FAIL abort_is_waits_core got busy=%b want 1", busy);
    end
    wait_idle("abort_is");
    repeat (10) @(negedge raw_clk);
    total++;
    if (core_busy !== 1'b0 || n_we != we0 || n_done != dn0 || n_cs != cs0 + 2) begin
      bad++; $display("FAIL abort_is_quiet got core_busy=%b writes=%0d dones=%0d starts=%0d want 0 0 0 2",
                      core_busy, n_we - we0, n_done - dn0, n_cs - cs0);
    end
  endtask

  task automatic test_busy_start_reset();
    int cs0;
    cs0 = n_cs;
    start_frame(8'd5, 8'd1, 16'h0, 16'h0, 16'h0100, 16'h0);
    wait_cs("ignore_start", cs0 + 1);
    repeat (2) @(negedge raw_clk);
    start_frame(8'd1, 8'd1, 16'h1000, 16'h1000, 16'h0, 16'h0);
    total++;
    if (busy !== 1'b1 || mem_addr !== '0) begin
      bad++; $display("FAIL ignore_start_state got busy=%b addr=%h want 1 0", busy, mem_addr);
    end
    wait_cs("ignore_start", cs0 + 2);
    total++;
    if (core_r !== 16'h0100 || core_i !== 16'h0) begin
      bad++; $display("FAIL ignore_start_coord got r=%h i=%h want 0100 0000", core_r, core_i);
    end
    reset = 1'b1;
    @(negedge raw_clk);
    check_reset_outputs("mid_frame_reset");
    reset = 1'b0;
    repeat (5) @(negedge raw_clk);
    run_frame("after_reset", 8'd2, 8'd2, 16'h0, 16'h0, 16'h0800, 16'h0);
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; abort = 1'b0;
    r0 = '0; i0 = '0; dr = '0; di = '0; width = '0; height = '0;
    @(negedge raw_clk);
    test_reset();
    test_single_pixel();
    test_two_by_two();
    test_flush_and_throughput();
    test_mixed_frames();
    test_zero_size();
    test_abort_wait_done();
    test_abort_issue();
    test_busy_start_reset();
    repeat (5) @(negedge raw_clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mandelbrot_scanner.md
MANDELBROT_SCANNER -- requirements
Module: mandelbrot_scanner

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 12, width of the result-memory word address.
REQ-002 SHALL have port raw_clk  input  1  the single clock; all logic is on its rising edge.
REQ-003 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have ports start input 1 (frame request pulse) and abort input 1 (cancel the current frame).
REQ-005 SHALL have ports r0, i0, dr, di, each input 16, signed 6.10 fixed point: the origin and the per-pixel step.
REQ-006 SHALL have ports width and height, each input 8, giving the frame size in pixels; all config inputs are sampled only when start is accepted.
REQ-007 SHALL have ports core_start output 1, core_r output 16, core_i output 16, core_result input 4 and core_busy input 1, connecting to the Mandelbrot iteration core.
REQ-008 SHALL have ports mem_addr output ADDR_WIDTH, mem_data output 16 and mem_we output 1, forming the result-memory write port.
REQ-009 SHALL have ports busy output 1 (frame in progress) and done output 1 (one-cycle pulse at frame completion).

Function
REQ-010 SHALL implement states IDLE, ISSUE, WAIT_BUSY, WAIT_DONE, STORE, FLUSH and FINISH.
REQ-011 IDLE: when start=1 and abort=0, latch the config, set x=0, y=0, cur_r=r0, cur_i=i0, mem_addr=0 and the nibble index to 0, set busy=1, then go to ISSUE.
REQ-012 IDLE with width=0 or height=0 at start: go directly to FINISH; no core_start and no mem_we are issued.
REQ-013 ISSUE: drive core_start=1 for exactly one cycle with core_r=cur_r and core_i=cur_i, then go to WAIT_BUSY; core_r and core_i hold their values until the pixel's result is stored.
REQ-014 WAIT_BUSY: wait with core_start=0 until core_busy=1, then go to WAIT_DONE.
REQ-015 WAIT_DONE: wait until core_busy=0, capture core_result in that cycle, then go to STORE.
REQ-016 STORE: place the captured result at nibble [4k+3:4k] of the pack register, where k is the nibble index; pixel 0 of a word occupies bits [3:0].
REQ-017 STORE with k=3: assert mem_we=1 for one cycle with the full word, increment mem_addr modulo 2^ADDR_WIDTH, clear the pack register and set k=0; otherwise increment k.
REQ-018 STORE advances the coordinates. If x<width-1: x+1 and cur_r+=dr. Otherwise: x=0, cur_r=r0, y+1 and cur_i+=di.
REQ-019 All coordinate additions SHALL be 16-bit two's-complement with wrap and no saturation.
REQ-020 After STORE: if the pixel just stored was the last one (x=width-1 and y=height-1), go to FLUSH; otherwise go to ISSUE.
REQ-021 FLUSH: if k≠0, write the partial word with unused nibbles set to 0 (mem_we one cycle) and increment mem_addr; then go to FINISH.
REQ-022 FINISH: assert done=1 for one cycle, drop busy to 0 and return to IDLE.
REQ-023 SHALL ignore start while busy=1.
REQ-024 Abort in ISSUE or WAIT_BUSY: wait for the core's busy to rise and fall. Abort in WAIT_DONE: wait for core_busy=0. In both cases return to IDLE with no further mem_we and no done pulse; busy drops on return to IDLE.
REQ-025 Abort in STORE or FLUSH: complete any write already being made in that cycle, then return to IDLE without done.
REQ-026 SHALL write mem_data, and treat it as valid, only when mem_we=1.
REQ-027 SHALL give throughput of one pixel per (core latency + 3) cycles, with no gap between STORE and the next ISSUE.

Reset
REQ-028 On reset=1 at a clock edge SHALL enter IDLE and clear core_start, mem_we, done, busy, mem_addr, mem_data, core_r, core_i and k.
REQ-029 Reset SHALL take priority over start and abort in the same cycle, and applies at any point mid-frame.

Verification
REQ-030 width=1, height=1, r0=i0=0 -> a single write of 0x000F at address 0, then one done pulse, then busy=0.
REQ-031 width=2, height=2, r0=0, dr=0x0800, i0=di=0 -> a single write of 0x0F0F at address 0 (per-pixel results 15,0,15,0).
REQ-032 width=5, height=1, r0=dr=i0=di=0 -> write 0xFFFF at address 0, then flush 0x000F at address 1, then done.
REQ-033 width=0 with start -> done one cycle later; no core_start and no mem_we occur.
REQ-034 abort during WAIT_DONE of pixel 2 in the REQ-032 frame -> no write after the core finishes, no done, busy=0, and a later start is accepted.
REQ-035 start pulsed while busy, plus reset asserted mid-frame -> the start is ignored and all outputs take their REQ-028 values on the next edge.
